mem_line_responder: RTL



---
 rtl/cache.sv | 16 +
 rtl/mem_line_responder.sv | 103 ++++++++++
 2 files changed

// File: rtl/cache.sv
// Shared request/response types for the cache-to-memory line interface.
package cache;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_t;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_resp_t;

endpackage

// File: rtl/mem_line_responder.sv
// Fixed-latency memory-side responder for cache line fills and write-backs.
// One request in flight at a time; completion is a single-cycle ready pulse.
module mem_line_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  cache::mem_req_t  mem_req,
  output cache::mem_resp_t mem_resp,
  output logic             busy,
  output logic             addr_err
);

  localparam int unsigned Lines   = 2 ** DEPTH_LOG2;
  localparam logic [7:0]  CntLoad = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [127:0]            data_q, data_d;
  logic                    rw_q, rw_d;
  logic [127:0]            resp_data_q, resp_data_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    oor_q, oor_d;
  logic [127:0]            store_q [Lines];
  logic                    unused_addr_lsb;

  assign idx_q = addr_q[DEPTH_LOG2+3:4];
  assign idx_d = addr_d[DEPTH_LOG2+3:4];
  assign oor_q = (addr_q >> (DEPTH_LOG2 + 4)) != 32'd0;
  assign oor_d = (addr_d >> (DEPTH_LOG2 + 4)) != 32'd0;

  // Line offset bits never select anything: transfers are whole lines.
  assign unused_addr_lsb = ^addr_q[3:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req.valid) begin
          addr_d  = mem_req.addr;
          data_d  = mem_req.data;
          rw_d    = mem_req.rw;
          cnt_d   = CntLoad;
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Response data is captured on entry to RESP so the store read is registered
  // and sees the line before the same-cycle write-back commit.
  always_comb begin
    resp_data_d = resp_data_q;
    if (state_d == StResp) begin
      if (rw_d)       resp_data_d = data_d;
      else if (oor_d) resp_data_d = '0;
      else            resp_data_d = store_q[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rw_q        <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rw_q        <= rw_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Store is deliberately not reset; a reset mid-RESP clears state_q first,
  // so an abandoned write never commits.
  always_ff @(posedge clk) begin
    if (state_q == StResp && rw_q && !oor_q) store_q[idx_q] <= data_q;
  end

  assign mem_resp = '{data: resp_data_q, ready: (state_q == StResp)};
  assign busy     = (state_q != StIdle);
  assign addr_err = (state_q == StResp) && oor_q;

endmodule
